// File: rtl/skewer_pkg.sv
// Shared types and helpers for the array input skewer.
// Latency: none (package only).
// Backpressure: none (package only).
package skewer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Drain counter width: enough to hold ROWS-2, never narrower than one bit.
  function automatic int cnt_width(input int rows);
    return (rows > 2) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One skew lane: a DEPTH-stage register chain carrying data plus valid.
// Latency: DEPTH cycles from input to output.
// Backpressure: none; shifts every cycle unconditionally.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Shift data and valid together one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/array_input_skewer.sv
// Diagonal skewer feeding the systolic array: lane r delayed r+1 cycles; tile FSM with drain and done pulse.
// Latency: lane r presents a vector r+1 cycles after accept; done ROWS cycles after the last accept.
// Backpressure: in_ready low only while draining a tile; optional SKEWER_ZERO_BUBBLE_EN zeroes bubble data.
module array_input_skewer
  import skewer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] skew_data,
  output logic [ROWS-1:0]            skew_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int               CNT_W      = cnt_width(ROWS);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((ROWS >= 2) ? ROWS - 2 : 0);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_d;
  logic                      accept;
  logic [ROWS*DATA_WIDTH-1:0] entry_data;

  // Ready depends on state only, so no input-to-output combinational path.
  assign in_ready = (state_q != DRAIN);
  assign accept   = in_valid && in_ready;

  // Next-state, drain counter and done decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            if (ROWS == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end else begin
            state_d = FEED;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, busy and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
    end
  end

`ifdef SKEWER_ZERO_BUBBLE_EN
  // Bubbles carry zero data so accumulating PEs see a neutral operand.
  assign entry_data = accept ? in_data : '0;
`else
  // Bubble data is don't-care; skew_valid alone qualifies it.
  assign entry_data = in_data;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (entry_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .in_valid  (accept),
      .out_data  (skew_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (skew_valid[r])
    );
  end

endmodule

// File: tb/tb_array_input_skewer.sv
// Self-checking bench for array_input_skewer with a cycle-indexed accept-history model.
// Latency: n/a.
// Backpressure: n/a.
module tb_array_input_skewer;

  localparam int R  = 4;
  localparam int W  = 8;
  localparam int HN = 1024;
  localparam logic [R*W-1:0] JUNK = 32'hA5C3_5A3C;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [R*W-1:0] in_data;
  logic           in_last;
  logic [R*W-1:0] skew_data;
  logic [R-1:0]   skew_valid;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  array_input_skewer #(.DATA_WIDTH(W), .ROWS(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .skew_data  (skew_data),
    .skew_valid (skew_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: history of what was accepted at each edge ----------------
  // Edge e ends cycle e; cycle c is the interval between edge c-1 and edge c.
  logic           hist_vld  [HN];
  logic           hist_last [HN];
  logic [R*W-1:0] hist_dat  [HN];
  logic           open_h    [HN];
  int             e;

  // Not ready during cycles T+1 .. T+R-1 after a last vector accepted at edge T.
  function automatic bit m_ready(input int c);
    for (int t = c - (R - 1); t <= c - 1; t++) begin
      if (t >= 0 && hist_last[t]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    bit acc;
    if (!rst_n) begin
      e = 0;
    end else if (e < HN) begin
      rdy            = m_ready(e);
      acc            = in_valid && rdy;
      hist_vld[e]    = acc;
      hist_dat[e]    = in_data;
      hist_last[e]   = acc && in_last;
      open_h[e]      = acc ? !in_last : ((e > 0) ? open_h[e-1] : 1'b0);
      e              = e + 1;
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    int t;
    logic [R-1:0] exp_v;
    logic [W-1:0] exp_d;
    if (!rst_n) begin
      chk("rst skew_valid", 64'(skew_valid), 64'd0);
      chk("rst skew_data", 64'(skew_data), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
    end else begin
      exp_v = '0;
      for (int r = 0; r < R; r++) begin
        t = e - 1 - r;
        exp_v[r] = (t >= 0) && hist_vld[t];
        exp_d    = exp_v[r] ? hist_dat[t][r*W +: W] : '0;
`ifdef SKEWER_ZERO_BUBBLE_EN
        chk($sformatf("lane%0d data", r), 64'(skew_data[r*W +: W]), 64'(exp_d));
`else
        if (exp_v[r]) chk($sformatf("lane%0d data", r), 64'(skew_data[r*W +: W]), 64'(exp_d));
`endif
      end
      chk("skew_valid", 64'(skew_valid), 64'(exp_v));
      chk("in_ready", 64'(in_ready), 64'(m_ready(e)));
      chk("done", 64'(done), 64'((e >= R) && hist_last[e-R]));
      chk("busy", 64'(busy), 64'(!m_ready(e) || ((e > 0) && open_h[e-1])));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [R*W-1:0] vec(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Called at a negedge: drive inputs for the next edge, then move to the following negedge.
  task automatic tick(input logic v, input logic [R*W-1:0] d, input logic last);
    in_valid = v;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, JUNK, 1'b0);
  endtask

  function automatic logic [W-1:0] lane(input int r);
    return skew_data[r*W +: W];
  endfunction

  // Single-vector tile with hand-derived expectations (relative cycle numbers in names).
  task automatic single_tile;
    tick(1'b1, vec(1, 2, 3, 4), 1'b1);
    chk("s2 c1 valid", 64'(skew_valid), 64'b0001);
    chk("s2 c1 lane0", 64'(lane(0)), 64'd1);
    chk("s2 c1 ready", 64'(in_ready), 64'd0);
    tick(1'b0, JUNK, 1'b0);
    chk("s2 c2 valid", 64'(skew_valid), 64'b0010);
    chk("s2 c2 lane1", 64'(lane(1)), 64'd2);
    tick(1'b0, JUNK, 1'b0);
    chk("s2 c3 lane2", 64'(lane(2)), 64'd3);
    chk("s2 c3 ready", 64'(in_ready), 64'd0);
    tick(1'b0, JUNK, 1'b0);
    chk("s2 c4 valid", 64'(skew_valid), 64'b1000);
    chk("s2 c4 lane3", 64'(lane(3)), 64'd4);
    chk("s2 c4 done", 64'(done), 64'd1);
    chk("s2 c4 ready", 64'(in_ready), 64'd1);
    tick(1'b0, JUNK, 1'b0);
    chk("s2 c5 done", 64'(done), 64'd0);
    idle(2);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1: reset then idle
    idle(5);
    chk("s1 skew_valid", 64'(skew_valid), 64'd0);
    chk("s1 busy", 64'(busy), 64'd0);
    chk("s1 ready", 64'(in_ready), 64'd1);
    chk("s1 done", 64'(done), 64'd0);

    // 2: single vector tile
    single_tile();

    // 3: three back-to-back vectors
    tick(1'b1, vec(1, 2, 3, 4), 1'b0);
    chk("s3 c1 lane0", 64'(lane(0)), 64'd1);
    chk("s3 c1 busy", 64'(busy), 64'd1);
    tick(1'b1, vec(5, 6, 7, 8), 1'b0);
    chk("s3 c2 lane0", 64'(lane(0)), 64'd5);
    tick(1'b1, vec(9, 10, 11, 12), 1'b1);
    chk("s3 c3 lane0", 64'(lane(0)), 64'd9);
    tick(1'b0, JUNK, 1'b0);
    chk("s3 c4 lane3", 64'(lane(3)), 64'd4);
    tick(1'b0, JUNK, 1'b0);
    chk("s3 c5 lane3", 64'(lane(3)), 64'd8);
    tick(1'b0, JUNK, 1'b0);
    chk("s3 c6 lane3", 64'(lane(3)), 64'd12);
    chk("s3 c6 done", 64'(done), 64'd1);
    idle(2);

    // 4: one-cycle gap propagates diagonally
    tick(1'b1, vec(21, 22, 23, 24), 1'b0);
    tick(1'b0, JUNK, 1'b0);
    chk("s4 c2 busy", 64'(busy), 64'd1);
    tick(1'b1, vec(31, 32, 33, 34), 1'b1);
    chk("s4 c3 valid", 64'(skew_valid), 64'b0101);
    tick(1'b0, JUNK, 1'b0);
    chk("s4 c4 valid", 64'(skew_valid), 64'b1010);
    idle(4);

    // 5: in_valid held through drain; next tile taken in the done cycle
    tick(1'b1, vec(41, 42, 43, 44), 1'b1);
    repeat (3) tick(1'b1, vec(51, 52, 53, 54), 1'b0);
    chk("s5 c4 done", 64'(done), 64'd1);
    chk("s5 c4 ready", 64'(in_ready), 64'd1);
    chk("s5 c4 valid0", 64'(skew_valid[0]), 64'd0);
    tick(1'b1, vec(51, 52, 53, 54), 1'b0);
    chk("s5 c5 valid0", 64'(skew_valid[0]), 64'd1);
    chk("s5 c5 lane0", 64'(lane(0)), 64'd51);
    tick(1'b1, vec(61, 62, 63, 64), 1'b1);
    idle(5);

    // 6: asynchronous reset mid-drain
    tick(1'b1, vec(71, 72, 73, 74), 1'b1);
    tick(1'b0, JUNK, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6 async valid", 64'(skew_valid), 64'd0);
    chk("s6 async data", 64'(skew_data), 64'd0);
    chk("s6 async busy", 64'(busy), 64'd0);
    chk("s6 async ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle(1);
    single_tile();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
